insn_fetch_ctrl: RTL and testbench
==================================

INSN_FETCH_CTRL -- requirements
Module: insn_fetch_ctrl

Interface
REQ-001 Parameter MEM_ADDR, default MEM_INSN_ADDR: instruction memory address width.
REQ-002 Parameter LEN_REG, default from defs_insn.v: instruction word width.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset, MEM_ADDR bits.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-006 en  input  1  fetch enable; low SHALL suppress new memory reads.
REQ-007 mem_a  output  MEM_ADDR  address to memory_insn A; SHALL be driven from a register.
REQ-008 mem_q  input  LEN_REG  data from memory_insn Q, valid the cycle after mem_a is sampled.
REQ-009 out_valid  output  1  out_insn/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1  consumer accepts; transfer occurs when out_valid && out_ready at posedge.
REQ-011 out_insn  output  LEN_REG  fetched instruction word.
REQ-012 out_pc  output  MEM_ADDR  address out_insn was read from.
REQ-013 redir_valid  input  1  one-cycle request to restart fetch at redir_pc.
REQ-014 redir_pc  input  MEM_ADDR  new fetch address.

Function
REQ-015 Block SHALL hold fetch_pc (drives mem_a), a 1-bit in-flight flag with its pc, and a 2-entry FIFO of {insn, pc}.
REQ-016 Issue SHALL occur at a posedge when en=1, redir_valid=0 and (fifo_count + inflight - pop) < 2, pop = out_valid && out_ready.
REQ-017 On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^MEM_ADDR (all-ones wraps to 0).
REQ-018 No issue: inflight<=0, fetch_pc unchanged.
REQ-019 When inflight=1 at a posedge (and no redirect), {mem_q, inflight_pc} SHALL be pushed into the FIFO.
REQ-020 mem_q SHALL be ignored whenever inflight=0 (memory_insn has no enable; Q always changes).
REQ-021 out_valid SHALL equal (fifo_count != 0); out_insn/out_pc SHALL show the FIFO head and SHALL be stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL keep count unchanged and preserve order; FIFO SHALL never overflow (guaranteed by REQ-016).
REQ-023 Latency: instruction issued at edge e SHALL be visible on out_* after edge e+1; sustained throughput 1 instruction/cycle with out_ready=1.
REQ-024 Redirect at a posedge SHALL: empty the FIFO, clear inflight (discarding the in-flight word), set fetch_pc<=redir_pc; out_valid SHALL be 0 the following cycle.
REQ-025 Redirect SHALL take priority over issue, push and pop in the same cycle; a pop coinciding with redirect is still a completed transfer.
REQ-026 en=0 SHALL not cancel an in-flight read; it SHALL complete into the FIFO.
REQ-027 State machine: RESET (rst high) -> RUN; RUN self-loops; redirect and en are qualifiers only, no extra states.

Reset
REQ-028 While rst=1: fetch_pc=RESET_PC, mem_a=RESET_PC, inflight=0, fifo_count=0, out_valid=0; out_insn/out_pc SHALL be 0.
REQ-029 rst asserted mid-operation SHALL immediately discard in-flight and queued instructions.
REQ-030 First issue SHALL occur at the first posedge after rst deasserts with en=1.

Verification
REQ-031 Reset release, en=1, out_ready=1, RESET_PC=0 -> out_pc 0,1,2,3 on consecutive cycles, first valid 2 edges after release, out_insn = memory contents.
REQ-032 out_ready=0 for 5 cycles after first valid -> out_valid held, out_pc=0 stable, no more than 2 entries queued; ready=1 then -> pcs 0,1,2 with no gap or duplicate.
REQ-033 Redirect to 0x10 while FIFO full and read in flight -> out_valid=0 next cycle, next delivered out_pc=0x10, no old pc ever appears afterward.
REQ-034 fetch_pc at 2^MEM_ADDR-1 -> delivered out_pc sequence all-ones, 0, 1.
REQ-035 en dropped for 3 cycles mid-stream -> in-flight word delivered, then no new out_pc until en=1; sequence resumes without skip.
REQ-036 rst pulsed while out_valid=1 -> out_valid=0 asynchronously; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/insn_fetch_ctrl.sv
// insn_fetch_ctrl: sequential instruction fetcher for a synchronous-read
// instruction memory. Keeps at most one read in flight plus a 2-entry
// {insn, pc} output queue, so a stalled consumer never loses a word, and
// supports a one-cycle redirect that flushes everything fetched so far.
module insn_fetch_ctrl #(
    parameter int                  MEM_ADDR = 8,
    parameter int                  LEN_REG  = 32,
    parameter logic [MEM_ADDR-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [MEM_ADDR-1:0] mem_a,
    input  logic [LEN_REG-1:0]  mem_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_REG-1:0]  out_insn,
    output logic [MEM_ADDR-1:0] out_pc,
    input  logic                redir_valid,
    input  logic [MEM_ADDR-1:0] redir_pc
);

    localparam logic [MEM_ADDR-1:0] PC_ONE = 1;

    typedef enum logic {
        ST_RESET,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Fetch side: address register and the single outstanding read.
    logic [MEM_ADDR-1:0] r_fetch_pc;
    logic                r_inflight;
    logic [MEM_ADDR-1:0] r_inflight_pc;

    // Output queue: two entries, head at r_rd_ptr.
    logic [LEN_REG-1:0]  r_fifo_insn [2];
    logic [MEM_ADDR-1:0] r_fifo_pc   [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [2:0]          w_occupancy;

    // State register: leaves RESET on the first clock after rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle control decode. Redirect and en only qualify
    // the controls; they never change state. Issue is not gated on RUN so
    // the first fetch happens on the first edge after reset release.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_issue      = 1'b0;
        w_occupancy  = 3'd0;

        case (r_state)
            ST_RESET: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_RESET;
        endcase

        w_pop = out_valid && out_ready;
        // Slots already committed after this edge: queued + arriving - leaving.
        w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_push  = r_inflight && !redir_valid;
        w_issue = en && !redir_valid && (w_occupancy < 3'd2);
    end

    // Fetch address and in-flight tracking; redirect overrides issue.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every block
        // samples pre-edge values regardless of evaluation order.
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redir_valid) begin
            r_fetch_pc <= redir_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + PC_ONE;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Output queue: capture returning reads, retire accepted heads, flush on
    // redirect. A pop during redirect is still a completed transfer; the
    // flush simply discards whatever remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two storage entries are reset on purpose so out_insn
            // and out_pc read zero while in reset; deeper arrays would not be.
            for (int i = 0; i < 2; i++) begin
                r_fifo_insn[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redir_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_insn[r_wr_ptr] <= mem_q;
                r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign mem_a     = r_fetch_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_insn  = r_fifo_insn[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// tb_insn_fetch_ctrl: directed bench for insn_fetch_ctrl with a behavioural
// synchronous-read memory. Stimulus pushes expected pcs into a queue; an
// independent monitor compares every accepted transfer against it.
module tb_insn_fetch_ctrl;

    localparam int MEM_ADDR = 5;
    localparam int LEN_REG  = 32;

    logic                clk;
    logic                rst;
    logic                en;
    logic [MEM_ADDR-1:0] mem_a;
    logic [LEN_REG-1:0]  mem_q;
    logic                out_valid;
    logic                out_ready;
    logic [LEN_REG-1:0]  out_insn;
    logic [MEM_ADDR-1:0] out_pc;
    logic                redir_valid;
    logic [MEM_ADDR-1:0] redir_pc;

    logic [LEN_REG-1:0]  mem [32];
    logic [MEM_ADDR-1:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    insn_fetch_ctrl #(
        .MEM_ADDR (MEM_ADDR),
        .LEN_REG  (LEN_REG),
        .RESET_PC (5'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mem_a       (mem_a),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_insn    (out_insn),
        .out_pc      (out_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, easily recognised word per address.
    function automatic logic [31:0] insn_of(input logic [4:0] pc);
        return {16'hC0DE, 3'b101, pc, 3'b010, pc};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = insn_of(5'(i));
    end

    // Synchronous-read memory: Q reflects the address sampled at the edge.
    always @(posedge clk) mem_q <= mem[mem_a];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got pc %0h expected none", out_pc);
            end else begin
                logic [MEM_ADDR-1:0] e;
                e = exp_q.pop_front();
                check("out_pc", 64'(out_pc), 64'(e));
                check("out_insn", 64'(out_insn), 64'(insn_of(e)));
            end
        end
    end

    // Wait for the scoreboard to empty, then stall the DUT.
    task automatic drain(input string name, input int limit, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        en        = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic [MEM_ADDR-1:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        @(posedge clk); #1;
        redir_valid = 1'b0;
        check("redir_valid_clear", 64'(out_valid), 64'd0);
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        out_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;

        // Reset state.
        edges(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_mem_a", 64'(mem_a), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_insn", 64'(out_insn), 64'd0);

        // Streaming from RESET_PC: first valid two edges after release.
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(5'(i));
        edges(1);
        check("p1_valid_edge1", 64'(out_valid), 64'd0);
        edges(1);
        check("p1_valid_edge2", 64'(out_valid), 64'd1);
        drain("p1", 20, cyc);
        check("p1_back_to_back", 64'(cyc), 64'd4);

        // Consumer stall: head held, queue caps at two, resumes without gap.
        do_redirect(5'd0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(5'(i));
        edges(2);
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("p2_hold_valid", 64'(out_valid), 64'd1);
            check("p2_hold_pc", 64'(out_pc), 64'd0);
            check("p2_hold_insn", 64'(out_insn), 64'(insn_of(5'd0)));
            check("p2_fetch_stalled", 64'(mem_a), 64'd2);
        end
        out_ready = 1'b1;
        drain("p2", 20, cyc);
        check("p2_resume_no_gap", 64'(cyc), 64'd3);

        // Redirect with a queued word being accepted and a read in flight.
        do_redirect(5'd0);
        en = 1'b1; out_ready = 1'b1;
        exp_q.push_back(5'h00);
        exp_q.push_back(5'h10);
        exp_q.push_back(5'h11);
        exp_q.push_back(5'h12);
        edges(2);
        redir_valid = 1'b1;
        redir_pc    = 5'h10;
        edges(1);
        redir_valid = 1'b0;
        check("p3_flushed", 64'(out_valid), 64'd0);
        drain("p3", 20, cyc);

        // Address wrap.
        do_redirect(5'h1f);
        en = 1'b1; out_ready = 1'b1;
        exp_q.push_back(5'h1f);
        exp_q.push_back(5'h00);
        exp_q.push_back(5'h01);
        drain("p4", 20, cyc);

        // Fetch enable dropped for three cycles mid-stream.
        do_redirect(5'd5);
        en = 1'b1; out_ready = 1'b1;
        for (int i = 5; i <= 10; i++) exp_q.push_back(5'(i));
        edges(3);
        en = 1'b0;
        edges(3);
        check("p5_inflight_delivered", 64'(exp_q.size()), 64'd3);
        check("p5_idle_valid", 64'(out_valid), 64'd0);
        check("p5_pc_held", 64'(mem_a), 64'd8);
        en = 1'b1;
        drain("p5", 20, cyc);

        // Asynchronous reset while holding a valid word.
        do_redirect(5'd9);
        en = 1'b1;
        edges(2);
        check("p6_valid_before_rst", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("p6_async_valid", 64'(out_valid), 64'd0);
        check("p6_async_pc", 64'(out_pc), 64'd0);
        check("p6_async_mem_a", 64'(mem_a), 64'd0);
        edges(1);
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(5'(i));
        drain("p6", 20, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
